// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and defaults for the VGA overlay compositor
package vga_pkg;

    localparam int COLOR_W_DEF = 8;
    localparam int COORD_W_DEF = 13;

    typedef enum logic [1:0] {
        MODE_OPAQUE = 2'd0,
        MODE_DIM    = 2'd1,
        MODE_BLEND  = 2'd2,
        MODE_OFF    = 2'd3
    } layer_mode_t;

    typedef struct packed {
        logic [COLOR_W_DEF-1:0] r;
        logic [COLOR_W_DEF-1:0] g;
        logic [COLOR_W_DEF-1:0] b;
    } rgb_t;

endpackage

// File: rtl/pixel_delay_line.sv
// rtl/pixel_delay_line.sv - resettable shift register, DEPTH=0 is a wire
module pixel_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_data = i_data;
        end else begin : g_shift
            logic [WIDTH-1:0] r_sr [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) r_sr[k] <= '0;
                end else begin
                    r_sr[0] <= i_data;
                    for (int k = 1; k < DEPTH; k++) r_sr[k] <= r_sr[k-1];
                end
            end

            assign o_data = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_overlay_compositor.sv
// rtl/vga_overlay_compositor.sv - aligns camera pixels with overlay hits and folds layers over them
module vga_overlay_compositor
    import vga_pkg::*;
#(
    parameter int NUM_LAYERS   = 8,
    parameter int LAT          = 2,
    parameter int COLOR_W      = COLOR_W_DEF,
    parameter int COORD_W      = COORD_W_DEF,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          game_en,
    input  logic                          in_valid,
    input  logic                          frame_start,
    input  logic [COLOR_W-1:0]            cam_r,
    input  logic [COLOR_W-1:0]            cam_g,
    input  logic [COLOR_W-1:0]            cam_b,
    input  logic [COORD_W-1:0]            row,
    input  logic [COORD_W-1:0]            col,
    input  logic [NUM_LAYERS-1:0]         layer_hit,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0] layer_color,
    input  logic [NUM_LAYERS*2-1:0]       layer_mode,
    input  logic [NUM_LAYERS-1:0]         layer_blink,
    output logic [COLOR_W-1:0]            out_r,
    output logic [COLOR_W-1:0]            out_g,
    output logic [COLOR_W-1:0]            out_b,
    output logic [COORD_W-1:0]            out_row,
    output logic [COORD_W-1:0]            out_col,
    output logic                          out_valid,
    output logic                          blink_phase
);

    localparam int BUS_W = 3 + 3*COLOR_W + 2*COORD_W;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

    logic [BUS_W-1:0]   w_bus_in;
    logic [BUS_W-1:0]   w_bus_dly;
    logic               w_game_en, w_valid, w_fs;
    logic [COLOR_W-1:0] w_cam_r, w_cam_g, w_cam_b;
    logic [COORD_W-1:0] w_row, w_col;

    assign w_bus_in = {game_en, in_valid, frame_start, cam_r, cam_g, cam_b, row, col};

    pixel_delay_line #(
        .WIDTH (BUS_W),
        .DEPTH (LAT)
    ) u_delay (
        .clk    (clk),
        .rst    (rst),
        .i_data (w_bus_in),
        .o_data (w_bus_dly)
    );

    assign {w_game_en, w_valid, w_fs, w_cam_r, w_cam_g, w_cam_b, w_row, w_col} = w_bus_dly;

    // Blink counter: the frame_start pixel itself is composed with the updated phase.
    logic [CNT_W-1:0] r_frame_cnt, w_cnt_nxt;
    logic             r_phase, w_phase_nxt;

    always_comb begin
        w_cnt_nxt   = r_frame_cnt;
        w_phase_nxt = r_phase;
        if (w_fs) begin
            if (r_frame_cnt == CNT_MAX) begin
                w_cnt_nxt   = '0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_cnt_nxt = r_frame_cnt + 1'b1;
            end
        end
    end

    function automatic logic [COLOR_W-1:0] avg(input logic [COLOR_W-1:0] a, input logic [COLOR_W-1:0] b);
        logic [COLOR_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[COLOR_W:1];
    endfunction

    logic [COLOR_W-1:0]   w_acc_r, w_acc_g, w_acc_b;
    logic [3*COLOR_W-1:0] w_col_i;
    layer_mode_t          w_mode_i;

    always_comb begin
        w_acc_r  = w_cam_r;
        w_acc_g  = w_cam_g;
        w_acc_b  = w_cam_b;
        w_col_i  = '0;
        w_mode_i = MODE_OFF;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            w_col_i  = layer_color[i*3*COLOR_W +: 3*COLOR_W];
            w_mode_i = layer_mode_t'(layer_mode[i*2 +: 2]);
            if (w_game_en && layer_hit[i] && (!layer_blink[i] || w_phase_nxt)) begin
                case (w_mode_i)
                    MODE_OPAQUE: begin
                        w_acc_r = w_col_i[3*COLOR_W-1:2*COLOR_W];
                        w_acc_g = w_col_i[2*COLOR_W-1:COLOR_W];
                        w_acc_b = w_col_i[COLOR_W-1:0];
                    end
                    MODE_DIM: begin
                        w_acc_r = w_acc_r >> 1;
                        w_acc_g = w_acc_g >> 1;
                        w_acc_b = w_acc_b >> 1;
                    end
                    MODE_BLEND: begin
                        w_acc_r = avg(w_acc_r, w_col_i[3*COLOR_W-1:2*COLOR_W]);
                        w_acc_g = avg(w_acc_g, w_col_i[2*COLOR_W-1:COLOR_W]);
                        w_acc_b = avg(w_acc_b, w_col_i[COLOR_W-1:0]);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_phase     <= 1'b1;
            out_r       <= '0;
            out_g       <= '0;
            out_b       <= '0;
            out_row     <= '0;
            out_col     <= '0;
            out_valid   <= 1'b0;
        end else begin
            r_frame_cnt <= w_cnt_nxt;
            r_phase     <= w_phase_nxt;
            out_r       <= w_valid ? w_acc_r : '0;
            out_g       <= w_valid ? w_acc_g : '0;
            out_b       <= w_valid ? w_acc_b : '0;
            out_row     <= w_row;
            out_col     <= w_col;
            out_valid   <= w_valid;
        end
    end

    assign blink_phase = r_phase;

endmodule

// File: tb/tb_vga_overlay_compositor.sv
// tb/tb_vga_overlay_compositor.sv - directed self-checking bench for vga_overlay_compositor
module tb_vga_overlay_compositor;
    import vga_pkg::*;

    localparam int NL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          game_en, in_valid, frame_start;
    logic [7:0]    cam_r, cam_g, cam_b;
    logic [12:0]   row, col;
    logic [NL-1:0] layer_hit;
    logic [NL*24-1:0] layer_color;
    logic [NL*2-1:0]  layer_mode;
    logic [NL-1:0] layer_blink;
    logic [7:0]    out_r, out_g, out_b;
    logic [12:0]   out_row, out_col;
    logic          out_valid, blink_phase;

    int errors = 0;
    int checks = 0;
    int m_cnt  = 0;
    logic m_ph = 1'b1;

    vga_overlay_compositor #(
        .NUM_LAYERS   (NL),
        .LAT          (2),
        .COLOR_W      (8),
        .COORD_W      (13),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .game_en     (game_en),
        .in_valid    (in_valid),
        .frame_start (frame_start),
        .cam_r       (cam_r),
        .cam_g       (cam_g),
        .cam_b       (cam_b),
        .row         (row),
        .col         (col),
        .layer_hit   (layer_hit),
        .layer_color (layer_color),
        .layer_mode  (layer_mode),
        .layer_blink (layer_blink),
        .out_r       (out_r),
        .out_g       (out_g),
        .out_b       (out_b),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_valid   (out_valid),
        .blink_phase (blink_phase)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step3();
        step(); step(); step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rgb();
        return {8'h00, out_r, out_g, out_b};
    endfunction

    task automatic set_layer(input int i, input logic [23:0] c, input layer_mode_t m, input logic b);
        layer_color[i*24 +: 24] = c;
        layer_mode[i*2 +: 2]    = m;
        layer_blink[i]          = b;
    endtask

    task automatic set_cam(input logic [23:0] c);
        {cam_r, cam_g, cam_b} = c;
    endtask

    task automatic model_fs();
        if (m_cnt == 1) begin
            m_cnt = 0;
            m_ph  = ~m_ph;
        end else begin
            m_cnt = m_cnt + 1;
        end
    endtask

    initial begin
        rst = 1'b1; game_en = 1'b0; in_valid = 1'b0; frame_start = 1'b0;
        set_cam(24'h0); row = '0; col = '0;
        layer_hit = '0; layer_color = '0; layer_mode = '1; layer_blink = '0;
        step(); step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_rgb", rgb(), 32'h0);
        chk("rst_phase", 32'(blink_phase), 32'd1);
        rst = 1'b0;

        // Single-pixel pulse: appears exactly three edges later.
        game_en = 1'b1; in_valid = 1'b1; set_cam(24'h804020); row = 13'd5; col = 13'd7;
        step();
        in_valid = 1'b0; set_cam(24'h0); row = '0; col = '0;
        chk("lat_e1_valid", 32'(out_valid), 32'd0);
        step();
        chk("lat_e2_valid", 32'(out_valid), 32'd0);
        step();
        chk("lat_e3_rgb", rgb(), 32'h804020);
        chk("lat_e3_row", 32'(out_row), 32'd5);
        chk("lat_e3_col", 32'(out_col), 32'd7);
        chk("lat_e3_valid", 32'(out_valid), 32'd1);
        step();
        chk("lat_e4_rgb", rgb(), 32'h0);
        chk("lat_e4_valid", 32'(out_valid), 32'd0);

        in_valid = 1'b1;
        set_layer(0, 24'hFF0000, MODE_OPAQUE, 1'b0);
        set_layer(1, 24'h00FF00, MODE_BLEND, 1'b0);
        set_layer(2, 24'h000000, MODE_DIM, 1'b0);
        set_layer(4, 24'h123456, MODE_OFF, 1'b0);
        set_cam(24'h804020); layer_hit = 8'b0000_0011;
        step3();
        chk("opaque_blend", rgb(), 32'h7F7F00);

        layer_hit = 8'b0000_0111;
        step3();
        chk("opaque_blend_dim", rgb(), 32'h3F3F00);

        set_cam(24'h814003); layer_hit = 8'b0000_0100;
        step3();
        chk("dim", rgb(), 32'h402001);

        game_en = 1'b0;
        step3();
        chk("game_off", rgb(), 32'h814003);

        game_en = 1'b1; layer_hit = 8'b0001_0000;
        step3();
        chk("mode_off", rgb(), 32'h814003);

        // Blinking white layer 3, frame_start every 10 cycles.
        set_layer(3, 24'hFFFFFF, MODE_OPAQUE, 1'b1);
        set_cam(24'h102030); layer_hit = 8'b0000_1000;
        step3();
        chk("blink_f0_rgb", rgb(), 32'hFFFFFF);
        chk("blink_f0_phase", 32'(blink_phase), 32'd1);

        for (int f = 1; f <= 4; f++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            step();
            if (f == 2) begin
                chk("blink_pre_fs_rgb", rgb(), 32'hFFFFFF);
                chk("blink_pre_fs_phase", 32'(blink_phase), 32'd1);
            end
            model_fs();
            step();
            chk($sformatf("blink_f%0d_fs_rgb", f), rgb(), m_ph ? 32'hFFFFFF : 32'h102030);
            chk($sformatf("blink_f%0d_phase", f), 32'(blink_phase), 32'(m_ph));
            repeat (7) step();
            chk($sformatf("blink_f%0d_mid_rgb", f), rgb(), m_ph ? 32'hFFFFFF : 32'h102030);
        end

        in_valid = 1'b0; row = 13'd9; col = 13'd3;
        step3();
        chk("blank_rgb", rgb(), 32'h0);
        chk("blank_valid", 32'(out_valid), 32'd0);
        chk("blank_row", 32'(out_row), 32'd9);
        chk("blank_col", 32'(out_col), 32'd3);

        // frame_start during blanking still advances the counter.
        frame_start = 1'b1; step(); frame_start = 1'b0; model_fs();
        step(); step();
        frame_start = 1'b1; step(); frame_start = 1'b0; model_fs();
        step(); step();
        chk("fs_blank_phase", 32'(blink_phase), 32'(m_ph));

        in_valid = 1'b1;
        step3();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_rgb", rgb(), m_ph ? 32'hFFFFFF : 32'h102030);

        rst = 1'b1;
        #2;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_rgb", rgb(), 32'h0);
        chk("async_rst_phase", 32'(blink_phase), 32'd1);
        m_cnt = 0; m_ph = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("post_rst_e1_valid", 32'(out_valid), 32'd0);
        step();
        chk("post_rst_e2_valid", 32'(out_valid), 32'd0);
        step();
        chk("post_rst_e3_valid", 32'(out_valid), 32'd1);
        chk("post_rst_e3_rgb", rgb(), 32'hFFFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
